// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet nibble receiver: FSM states, framing
// nibbles, error flags and CRC-32 constants.
package eth_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PREAMBLE  = 3'd1,
    ST_DATA      = 3'd2,
    ST_DROP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } state_t;

  typedef struct packed {
    logic overflow;
    logic oversize;
    logic align;
  } err_t;

  localparam logic [3:0]  PRE_NIBBLE  = 4'h5;
  localparam logic [3:0]  SFD_NIBBLE  = 4'hD;

  localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

  // The CRC register runs LSB-first, so polynomial and residue are kept in
  // their usual MSB-first form and mirrored where they meet the register.
  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// Combinational reflected CRC-32 update for one data byte.
module crc32_d8
  import eth_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [7:0]  data,
  output logic [31:0] crc_next
);

  localparam logic [31:0] POLY_REFL = reflect32(CRC_POLY);

  logic [31:0] c;

  // NOTE: c gets a full default before the loop so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    c = crc ^ {24'd0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ POLY_REFL) : (c >> 1);
    end
    crc_next = c;
  end

endmodule

// File: rtl/ethernet_rx.sv
// Ethernet receive front end: strips preamble/SFD, assembles nibbles into
// bytes, checks FCS and length, and reports per-frame status.
module ethernet_rx
  import eth_pkg::*;
#(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518,
  parameter int MIN_PRE = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_ctrl,
  input  logic [3:0]  phy_rxd,
  input  logic        fifo_full,
  output logic [7:0]  data_out,
  output logic        data_valid,
  output logic        frame_done,
  output logic        frame_good,
  output logic [10:0] byte_count
);

  localparam logic [10:0] MIN_LEN_W = 11'(MIN_LEN);
  localparam logic [10:0] MAX_LEN_W = 11'(MAX_LEN);
  localparam logic [3:0]  MIN_PRE_W = 4'(MIN_PRE);

  logic        ctrl_q;
  logic [3:0]  rxd_q;
  state_t      state;
  logic [3:0]  pre_cnt;
  logic [3:0]  lo_q;
  logic        hi_phase;
  logic [31:0] crc_q;
  logic [31:0] crc_next;
  err_t        err;
  logic        crc_ok;
  logic        len_ok;

  // NOTE: the input stage is deliberately left out of reset so that, after a
  // mid-frame reset, WAIT_IDLE sees the real line state rather than a forced 0.
  always_ff @(posedge clk) begin
    ctrl_q <= rx_ctrl;
    rxd_q  <= phy_rxd;
  end

  crc32_d8 u_crc (
    .crc      (crc_q),
    .data     ({rxd_q, lo_q}),
    .crc_next (crc_next)
  );

  assign crc_ok = (reflect32(crc_q) == CRC_RESIDUE);
  assign len_ok = (byte_count >= MIN_LEN_W);

  // NOTE: all state here is sequential, so every assignment is non-blocking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_WAIT_IDLE;
      data_out   <= 8'h00;
      data_valid <= 1'b0;
      frame_done <= 1'b0;
      frame_good <= 1'b0;
      byte_count <= '0;
      crc_q      <= CRC_INIT;
      err        <= '0;
      pre_cnt    <= '0;
      lo_q       <= '0;
      hi_phase   <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      frame_done <= 1'b0;
      frame_good <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ctrl_q && rxd_q == PRE_NIBBLE) begin
            state   <= ST_PREAMBLE;
            pre_cnt <= 4'd1;
          end
        end
        ST_PREAMBLE: begin
          if (!ctrl_q) begin
            state <= ST_IDLE;
          end else if (rxd_q == PRE_NIBBLE) begin
            if (pre_cnt != 4'hF) pre_cnt <= pre_cnt + 4'd1;
          end else if (rxd_q == SFD_NIBBLE && pre_cnt >= MIN_PRE_W) begin
            state      <= ST_DATA;
            hi_phase   <= 1'b0;
            byte_count <= '0;
            crc_q      <= CRC_INIT;
            err        <= '0;
          end else begin
            state <= ST_WAIT_IDLE;
          end
        end
        ST_DATA: begin
          if (!ctrl_q) begin
            // hi_phase set means the last nibble was an unpaired low nibble
            frame_done <= 1'b1;
            frame_good <= crc_ok && len_ok && (err == '0) && !hi_phase;
            if (hi_phase) err.align <= 1'b1;
            state <= ST_IDLE;
          end else if (!hi_phase) begin
            lo_q     <= rxd_q;
            hi_phase <= 1'b1;
          end else begin
            hi_phase <= 1'b0;
            if (fifo_full) begin
              err.overflow <= 1'b1;
              state        <= ST_DROP;
            end else if (byte_count == MAX_LEN_W) begin
              err.oversize <= 1'b1;
              state        <= ST_DROP;
            end else begin
              data_out   <= {rxd_q, lo_q};
              data_valid <= 1'b1;
              byte_count <= byte_count + 11'd1;
              crc_q      <= crc_next;
            end
          end
        end
        ST_DROP: begin
          if (!ctrl_q) begin
            frame_done <= 1'b1;
            state      <= ST_IDLE;
          end
        end
        ST_WAIT_IDLE: begin
          if (!ctrl_q) state <= ST_IDLE;
        end
        default: state <= ST_WAIT_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ethernet_rx.sv
// Directed bench for ethernet_rx: good/bad frames, alignment, overflow,
// oversize, short preamble, short frame and mid-frame reset.
module tb_ethernet_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_ctrl;
  logic [3:0]  phy_rxd;
  logic        fifo_full;
  logic [7:0]  data_out;
  logic        data_valid;
  logic        frame_done;
  logic        frame_good;
  logic [10:0] byte_count;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] tb_frame[$];
  int writes, data_err, done_cnt, overlap;
  logic last_good;
  logic [10:0] last_bc;

  ethernet_rx dut (
    .clk        (clk),
    .rst        (rst),
    .rx_ctrl    (rx_ctrl),
    .phy_rxd    (phy_rxd),
    .fifo_full  (fifo_full),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_done (frame_done),
    .frame_good (frame_good),
    .byte_count (byte_count)
  );

  always #20 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  always @(negedge clk) begin
    if (data_valid) begin
      if (writes < tb_frame.size() && data_out !== tb_frame[writes]) data_err++;
      writes++;
      if (frame_done) overlap++;
    end
    if (frame_done) begin
      done_cnt++;
      last_good = frame_good;
      last_bc   = byte_count;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d required %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic c, input logic [3:0] n);
    @(negedge clk);
    rx_ctrl = c;
    phy_rxd = n;
  endtask

  // full_at / rst_at are byte indices (0-based); -1 disables them.
  task automatic send_frame(input int npre, input int nbytes, input bit bad_fcs,
                            input bit extra_nib, input int full_at, input int rst_at);
    logic [31:0] c;
    logic [7:0]  b;
    tb_frame.delete();
    for (int i = 0; i < nbytes - 4; i++) tb_frame.push_back(8'(i * 13 + 5));
    c = 32'hFFFFFFFF;
    foreach (tb_frame[k]) begin
      c = c ^ {24'd0, tb_frame[k]};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    c = ~c;
    for (int k = 0; k < 4; k++) tb_frame.push_back(c[8*k +: 8]);
    if (bad_fcs) tb_frame[nbytes-1] = tb_frame[nbytes-1] ^ 8'h01;
    writes = 0; data_err = 0; done_cnt = 0; last_good = 1'bx; last_bc = 'x;

    for (int i = 0; i < npre; i++) drive(1'b1, 4'h5);
    drive(1'b1, 4'hD);
    for (int i = 0; i < nbytes; i++) begin
      b = tb_frame[i];
      if (i == rst_at) begin
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
      end
      drive(1'b1, b[3:0]);
      drive(1'b1, b[7:4]);
      if (i == full_at) fifo_full = 1'b1;
    end
    if (extra_nib) drive(1'b1, 4'hA);
    for (int i = 0; i < 12; i++) drive(1'b0, 4'h0);
    fifo_full = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rx_ctrl = 1'b0; phy_rxd = 4'h0; fifo_full = 1'b0; overlap = 0;
    repeat (4) @(negedge clk);
    check("rst_data_out",   32'(data_out),   32'h00);
    check("rst_data_valid", 32'(data_valid), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_frame_good", 32'(frame_good), 0);
    check("rst_byte_count", 32'(byte_count), 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    send_frame(7, 64, 1'b0, 1'b0, -1, -1);
    check("good_writes", 32'(writes), 64);
    check("good_data",   32'(data_err), 0);
    check("good_done",   32'(done_cnt), 1);
    check("good_status", 32'(last_good), 1);
    check("good_count",  32'(last_bc), 64);
    check("good_hold",   32'(byte_count), 64);

    send_frame(7, 64, 1'b1, 1'b0, -1, -1);
    check("badfcs_writes", 32'(writes), 64);
    check("badfcs_data",   32'(data_err), 0);
    check("badfcs_done",   32'(done_cnt), 1);
    check("badfcs_status", 32'(last_good), 0);

    send_frame(7, 64, 1'b0, 1'b1, -1, -1);
    check("odd_writes", 32'(writes), 64);
    check("odd_done",   32'(done_cnt), 1);
    check("odd_status", 32'(last_good), 0);

    send_frame(7, 64, 1'b0, 1'b0, 9, -1);
    check("ovf_writes", 32'(writes), 9);
    check("ovf_data",   32'(data_err), 0);
    check("ovf_done",   32'(done_cnt), 1);
    check("ovf_status", 32'(last_good), 0);
    check("ovf_count",  32'(last_bc), 9);

    send_frame(7, 1600, 1'b0, 1'b0, -1, -1);
    check("big_writes", 32'(writes), 1518);
    check("big_done",   32'(done_cnt), 1);
    check("big_status", 32'(last_good), 0);
    check("big_count",  32'(last_bc), 1518);

    send_frame(7, 64, 1'b0, 1'b0, -1, -1);
    check("after_big_status", 32'(last_good), 1);
    check("after_big_count",  32'(last_bc), 64);

    send_frame(6, 64, 1'b0, 1'b0, -1, -1);
    check("shortpre_writes", 32'(writes), 0);
    check("shortpre_done",   32'(done_cnt), 0);

    send_frame(7, 63, 1'b0, 1'b0, -1, -1);
    check("short_writes", 32'(writes), 63);
    check("short_status", 32'(last_good), 0);

    send_frame(7, 64, 1'b0, 1'b0, -1, 20);
    check("rstmid_done", 32'(done_cnt), 0);
    send_frame(7, 64, 1'b0, 1'b0, -1, -1);
    check("rstmid_next_writes", 32'(writes), 64);
    check("rstmid_next_status", 32'(last_good), 1);

    check("strobe_overlap", 32'(overlap), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ethernet_rx.md
ETHERNET_RX -- requirements
Module: ethernet_rx

Interface
REQ-001 Parameter MIN_LEN, default 64, minimum frame length in bytes after SFD, FCS included.
REQ-002 Parameter MAX_LEN, default 1518, maximum frame length in bytes after SFD, FCS included.
REQ-003 Parameter MIN_PRE, default 7, minimum count of 0x5 preamble nibbles before the SFD nibble.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset.
REQ-005 clk  input  1  25 MHz PHY receive clock; all logic on rising edge.
REQ-006 rst  input  1  synchronous reset, active high.
REQ-007 rx_ctrl  input  1  PHY receive-data-valid.
REQ-008 phy_rxd  input  4  PHY receive nibble, low nibble of each byte first.
REQ-009 fifo_full  input  1  downstream FIFO full.
REQ-010 data_out  output  8  assembled frame byte.
REQ-011 data_valid  output  1  one-cycle write strobe for data_out.
REQ-012 frame_done  output  1  one-cycle pulse at end of every frame that reached DATA.
REQ-013 frame_good  output  1  frame status, valid only while frame_done is high.
REQ-014 byte_count  output  11  bytes written for the current or last frame; saturates at MAX_LEN.

Function
REQ-015 rx_ctrl and phy_rxd SHALL be registered once before any decoding.
REQ-016 States: IDLE, PREAMBLE, DATA, DROP, WAIT_IDLE.
REQ-017 IDLE -> PREAMBLE on registered rx_ctrl=1 with nibble 0x5; nibble counter = 1.
REQ-018 PREAMBLE: nibble 0x5 increments the counter, saturating at 15.
REQ-019 PREAMBLE: nibble 0xD with counter >= MIN_PRE -> DATA; nibble phase reset to low nibble.
REQ-020 PREAMBLE: any other nibble, or 0xD with counter < MIN_PRE -> WAIT_IDLE; no frame_done.
REQ-021 PREAMBLE: rx_ctrl=0 -> IDLE; no frame_done.
REQ-022 DATA: the low nibble SHALL be held in a register.
REQ-023 DATA: the high nibble completes the byte {hi,lo}; data_out is driven and data_valid pulses in the next cycle (latency 1 clk after the high nibble is registered).
REQ-024 Every written byte, FCS included, SHALL update a CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF).
REQ-025 The frame CRC is correct when the residue after the last byte equals 0xC704DD7B.
REQ-026 If fifo_full=1 on a byte-completion cycle, that byte SHALL not be written, the frame SHALL be marked overflow, and the state SHALL go to DROP.
REQ-027 If byte_count would exceed MAX_LEN, that byte SHALL not be written, the frame SHALL be marked oversize, and the state SHALL go to DROP.
REQ-028 DATA: rx_ctrl falling after a high nibble -> frame_done pulse in the next cycle, then IDLE.
REQ-029 DATA: rx_ctrl falling after a low nibble -> frame marked alignment error, frame_done pulse, then IDLE; the partial nibble is discarded.
REQ-030 DROP: no writes; rx_ctrl falling -> frame_done with frame_good=0, then IDLE.
REQ-031 WAIT_IDLE: no outputs; rx_ctrl=0 -> IDLE.
REQ-032 frame_good = CRC correct AND no error flag AND byte_count >= MIN_LEN.
REQ-033 byte_count SHALL clear on entry to DATA and hold its value after frame_done until the next SFD.
REQ-034 data_valid and frame_done SHALL never be high in the same cycle.

Reset
REQ-035 rst SHALL force all of the following:
- state to WAIT_IDLE, so the block does not lock onto the middle of a frame;
- data_out = 0x00, data_valid = 0, frame_done = 0, frame_good = 0, byte_count = 0;
- CRC register = 0xFFFFFFFF and all error flags cleared.
REQ-036 rst asserted mid-frame SHALL abort the frame with no frame_done; reception resumes only after rx_ctrl=0 has been seen.

Structure
REQ-037 A shared package eth_pkg SHALL hold:
- the state enum;
- the preamble nibble 0x5 and SFD nibble 0xD;
- the CRC polynomial, init value and residue constants.
REQ-038 The CRC update SHALL be a sub-module crc32_d8: combinational next-CRC from the current CRC and one data byte.
REQ-039 The FSM, nibble assembly, counters and flags SHALL stay in ethernet_rx.

Verification
REQ-040 Good frame: 7x 0x5, 0xD, then a 64-byte valid frame with correct FCS -> 64 data_valid pulses with correct bytes, frame_done=1, frame_good=1, byte_count=64.
REQ-041 Bad FCS: the same frame with the last FCS byte XOR 0x01 -> 64 writes, frame_good=0.
REQ-042 Odd nibble: rx_ctrl drops after 129 data nibbles -> 64 writes, frame_good=0 (alignment error).
REQ-043 Overflow: fifo_full=1 from byte 10 onward -> exactly 9 writes, no writes in DROP, frame_done with frame_good=0, byte_count=9.
REQ-044 Oversize: a 1600-byte frame -> 1518 writes, byte_count=1518, frame_good=0; a following good 64-byte frame -> frame_good=1.
REQ-045 Reset mid-frame: rst at byte 20, rx_ctrl still high -> no frame_done; the next frame after an idle gap is received good.
